// File: rtl/fft_seq_pkg.sv
// Shared types and constants for the FFT frame sequencer.
package fft_seq_pkg;

  localparam int FFT_LENGTH_DEF = 1024;  // default samples per frame
  localparam int ADC_W          = 12;    // ADC sample width
  localparam int IDX_W          = 11;    // FFT bin index width
  localparam int OVR_CNT_W      = 8;     // dropped-sample counter width

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_BANK,
    ST_START,
    ST_FEED,
    ST_COLLECT,
    ST_DONE
  } seq_state_t;

endpackage

// File: rtl/dpram.sv
// Simple dual-port sample store: one write port, one registered read port.
module dpram #(
  parameter  int DEPTH = 2048,
  parameter  int W     = 12,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rdata;

  // Write port and registered read port share one clock.
  // NOTE: the array and read register carry no reset so the store maps onto block RAM.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fft_frame_sequencer.sv
// Ping-pong ADC frame buffer feeding an FFT core, NUM_FRAMES frames per start.
// Optional build macro FFT_SEQ_OVERRUN_COUNT_EN adds a saturating
// dropped-sample counter output overrun_count.
module fft_frame_sequencer
  import fft_seq_pkg::*;
#(
  parameter int FFT_LENGTH = FFT_LENGTH_DEF,
  parameter int NUM_FRAMES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             adc_data_valid,
  input  logic [ADC_W-1:0] adc_data,
  output logic             fft_start,
  output logic [ADC_W-1:0] fft_data,
  output logic             fft_data_valid,
  input  logic             fft_ready,
  input  logic             magnitude_ready,
  input  logic [IDX_W-1:0] index,
  output logic             frame_done,
  output logic             busy,
  output logic             done,
`ifdef FFT_SEQ_OVERRUN_COUNT_EN
  output logic [OVR_CNT_W-1:0] overrun_count,
`endif
  output logic             overrun
);

  localparam int                AW          = $clog2(FFT_LENGTH);
  localparam int                FC_W        = $clog2(NUM_FRAMES + 1);
  localparam logic [AW-1:0]     PTR_LAST    = AW'(FFT_LENGTH - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(FFT_LENGTH - 1);
  localparam logic [FC_W-1:0]   FRAMES      = FC_W'(NUM_FRAMES);
  localparam logic [FC_W-1:0]   FRAMES_LAST = FC_W'(NUM_FRAMES - 1);

  seq_state_t       r_state, w_state_nxt;
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr, w_rd_ptr_la;
  logic             r_fill_bank, r_rd_bank;
  logic [1:0]       r_bank_full, w_set_full, w_clr_full;
  logic [FC_W-1:0]  r_fill_cnt, r_frame_cnt;
  logic             r_overrun;
  logic [ADC_W-1:0] w_rdata;
  logic             w_run_start, w_busy, w_fill_open, w_we, w_drop, w_fill_wrap;
  logic             w_fire, w_feed_last, w_last_bin;

  assign w_run_start = (r_state == ST_IDLE) && start;
  assign w_busy      = (r_state != ST_IDLE) && (r_state != ST_DONE);
  // Once every frame of the run has been captured, the fill side goes quiet.
  assign w_fill_open = w_busy && (r_fill_cnt != FRAMES);
  assign w_we        = w_fill_open && adc_data_valid && !r_bank_full[r_fill_bank];
  assign w_drop      = w_fill_open && adc_data_valid &&  r_bank_full[r_fill_bank];
  assign w_fill_wrap = w_we && (r_wr_ptr == PTR_LAST);
  assign w_fire      = (r_state == ST_FEED) && fft_ready;
  assign w_feed_last = w_fire && (r_rd_ptr == PTR_LAST);
  assign w_last_bin  = (r_state == ST_COLLECT) && magnitude_ready && (index == IDX_LAST);

  // Look-ahead read address: the RAM read register always holds the sample at
  // r_rd_ptr, so it acts as the prefetch stage and a held address keeps
  // fft_data stable during stalls.
  assign w_rd_ptr_la = w_fire ? r_rd_ptr + AW'(1) : r_rd_ptr;

  assign w_set_full = {w_fill_wrap &  r_fill_bank, w_fill_wrap & ~r_fill_bank};
  assign w_clr_full = {w_feed_last &  r_rd_bank,   w_feed_last & ~r_rd_bank};

  dpram #(
    .DEPTH (2 * FFT_LENGTH),
    .W     (ADC_W)
  ) u_dpram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr ({r_fill_bank, r_wr_ptr}),
    .i_wdata (adc_data),
    .i_raddr ({r_rd_bank, w_rd_ptr_la}),
    .o_rdata (w_rdata)
  );

  // FSM state register.
  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state logic.
  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:      if (start) w_state_nxt = ST_WAIT_BANK;
      ST_WAIT_BANK: if (r_bank_full[r_rd_bank]) w_state_nxt = ST_START;
      ST_START:     w_state_nxt = ST_FEED;
      ST_FEED:      if (w_feed_last) w_state_nxt = ST_COLLECT;
      ST_COLLECT:   if (w_last_bin)
                      w_state_nxt = (r_frame_cnt == FRAMES_LAST) ? ST_DONE : ST_WAIT_BANK;
      ST_DONE:      if (!start) w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs; fft_data is gated so it reads zero outside the feed phase.
  always_comb begin
    fft_start      = (r_state == ST_START);
    fft_data_valid = (r_state == ST_FEED);
    fft_data       = (r_state == ST_FEED) ? w_rdata : '0;
    frame_done     = w_last_bin;
    busy           = w_busy;
    done           = (r_state == ST_DONE);
    overrun        = r_overrun;
  end

  // Fill pointer, read pointer, bank ownership and frame bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fill_bank <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_bank_full <= '0;
      r_fill_cnt  <= '0;
      r_frame_cnt <= '0;
      r_overrun   <= 1'b0;
    end else if (w_run_start) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fill_bank <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_bank_full <= '0;
      r_fill_cnt  <= '0;
      r_frame_cnt <= '0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_we) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_fill_wrap) begin
          r_fill_bank <= ~r_fill_bank;
          r_fill_cnt  <= r_fill_cnt + FC_W'(1);
        end
      end
      if (w_drop) r_overrun <= 1'b1;
      // Fill and release always target different banks, so both apply together.
      r_bank_full <= (r_bank_full | w_set_full) & ~w_clr_full;
      if (w_fire) begin
        r_rd_ptr <= w_rd_ptr_la;
        if (w_feed_last) r_rd_bank <= ~r_rd_bank;
      end
      if (w_last_bin) r_frame_cnt <= r_frame_cnt + FC_W'(1);
    end
  end

`ifdef FFT_SEQ_OVERRUN_COUNT_EN
  logic [OVR_CNT_W-1:0] r_ovr_cnt;

  // Saturating count of dropped samples, cleared at each run start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        r_ovr_cnt <= '0;
    else if (w_run_start)             r_ovr_cnt <= '0;
    else if (w_drop && (r_ovr_cnt != '1)) r_ovr_cnt <= r_ovr_cnt + OVR_CNT_W'(1);
  end

  assign overrun_count = r_ovr_cnt;
`endif

endmodule

// File: doc/fft_frame_sequencer.md
FFT_FRAME_SEQUENCER -- requirements
Module: fft_frame_sequencer

Interface
REQ-001 SHALL have parameter FFT_LENGTH, default 1024: samples per frame, power of two.
REQ-002 SHALL have parameter NUM_FRAMES, default 4: frames processed per start command.
REQ-003 SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: level input; high while in IDLE begins a run.
REQ-006 SHALL have port adc_data_valid, input, 1 bit: one-cycle strobe qualifying adc_data.
REQ-007 SHALL have port adc_data, input, 12 bits: unsigned ADC sample.
REQ-008 SHALL have port fft_start, output, 1 bit: one-cycle pulse before each frame feed.
REQ-009 SHALL have port fft_data, output, 12 bits: sample driven to the FFT core.
REQ-010 SHALL have port fft_data_valid, output, 1 bit: qualifies fft_data.
REQ-011 SHALL have port fft_ready, input, 1 bit: a transfer occurs when fft_data_valid && fft_ready.
REQ-012 SHALL have port magnitude_ready, input, 1 bit: FFT magnitude strobe.
REQ-013 SHALL have port index, input, 11 bits: bin index of the current magnitude.
REQ-014 SHALL have port frame_done, output, 1 bit: one-cycle pulse when a frame's last bin is received.
REQ-015 SHALL have port busy, output, 1 bit: high from run start until DONE is entered.
REQ-016 SHALL have port done, output, 1 bit: high while the FSM is in DONE.
REQ-017 SHALL have port overrun, output, 1 bit: sticky flag, set when a sample is dropped.

Function
REQ-018 SHALL buffer samples in two ping-pong banks of FFT_LENGTH entries, using write pointer wr_ptr (log2(FFT_LENGTH) bits) and bank select fill_bank.
REQ-019 Fill side SHALL ignore samples when not busy; when busy, each adc_data_valid SHALL write to fill_bank[wr_ptr] and increment wr_ptr; on wrap the bank SHALL be marked full and fill_bank SHALL toggle.
REQ-020 After NUM_FRAMES banks have been filled, further samples SHALL be ignored and SHALL NOT set overrun.
REQ-021 The feed FSM SHALL have states IDLE, WAIT_BANK, START, FEED, COLLECT and DONE.
REQ-022 IDLE SHALL go to WAIT_BANK when start=1, and SHALL clear pointers, frame_cnt, bank-full flags and overrun on that transition.
REQ-023 WAIT_BANK SHALL go to START when the oldest bank is full; START SHALL assert fft_start for exactly one cycle and then go to FEED.
REQ-024 In FEED, fft_data_valid SHALL be 1 and the read pointer SHALL advance once per handshake.
REQ-025 A prefetch register SHALL hide the RAM read latency so that fft_ready held at 1 gives 1024 consecutive handshakes, and fft_data SHALL hold stable while valid && !ready.
REQ-026 After the FFT_LENGTH-th handshake, FEED SHALL go to COLLECT and the fed bank SHALL be released as empty in that same cycle.
REQ-027 In COLLECT, magnitude_ready with index==FFT_LENGTH-1 SHALL pulse frame_done and increment frame_cnt.
REQ-028 After that last-bin event, COLLECT SHALL go to DONE if frame_cnt==NUM_FRAMES, otherwise to WAIT_BANK.
REQ-029 magnitude_ready SHALL be ignored in every state other than COLLECT.
REQ-030 DONE SHALL go to IDLE when start=0.
REQ-031 A start pulse arriving mid-run SHALL be ignored.
REQ-032 adc_data_valid while both banks are full SHALL drop the sample, leave wr_ptr unchanged and set overrun until the next run start.
REQ-033 A bank release and a fill completion in the same cycle SHALL both take effect, with no overrun.

Reset
REQ-034 While reset is asserted: FSM=IDLE, all pointers and counters=0, both banks empty, fft_start=fft_data_valid=frame_done=busy=done=overrun=0, fft_data=0; RAM contents are not cleared.
REQ-035 After reset deasserts, no output pulses SHALL occur until a new start.

Configuration
REQ-036 With FFT_SEQ_OVERRUN_COUNT_EN defined, the block SHALL add output overrun_count[7:0], counting dropped samples, saturating at 255, cleared by reset and by run start.
REQ-037 With FFT_SEQ_OVERRUN_COUNT_EN undefined, the overrun_count port SHALL be absent and only the sticky overrun flag SHALL exist.

Structure
REQ-038 Package fft_seq_pkg SHALL hold the FFT_LENGTH default, ADC_W=12, IDX_W=11 and enum seq_state_t.
REQ-039 Sample storage SHALL be one sub-module dpram (2*FFT_LENGTH x 12, one write port, one registered read port); all control logic SHALL live in fft_frame_sequencer.

Verification
REQ-040 Reset 20 cycles, start=1, 4096 samples of value n%4096 every 21 cycles, fft_ready=1, FFT model returns 1024 magnitudes after each feed -> 4 fft_start pulses, 4 frame_done pulses, fed data in sample order, done=1, overrun=0.
REQ-041 fft_ready high one cycle in three -> fft_data constant across stalls, exactly 1024 handshakes per frame.
REQ-042 fft_ready=0 throughout, samples every cycle -> overrun rises on the 2049th sample; with the macro defined, overrun_count=10 after 2058 samples.
REQ-043 reset asserted in FEED after 300 handshakes -> all outputs 0 immediately; a new start feeds frame 0 from bank 0.
REQ-044 magnitude_ready with index=1023 during FEED -> no frame_done, frame_cnt unchanged.
